// File: rtl/vga_timing_gen.sv
// 640x480@60Hz VGA scan timing: pixel-rate enable, h/v scan counters, registered syncs.
// Optional VGA_REFRESH_TICK_EN adds refr_tick, a once-per-frame pulse at the start of vertical blank.
module vga_timing_gen #(
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned H_DISP   = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_DISP   = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] pixel_x,
`ifdef VGA_REFRESH_TICK_EN
  output logic [9:0] pixel_y,
  output logic       refr_tick
`else
  output logic [9:0] pixel_y
`endif
);

  localparam int unsigned DW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);

  localparam logic [9:0] H_MAX    = 10'(H_DISP + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_MAX    = 10'(V_DISP + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISP);
  localparam logic [9:0] V_VIS    = 10'(V_DISP);
  localparam logic [9:0] HS_FIRST = 10'(H_DISP + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISP + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_DISP + V_FP + V_SYNC - 1);

  logic [DW-1:0] r_div_cnt;
  logic [9:0]    r_h_cnt;
  logic [9:0]    r_v_cnt;
  logic          r_hsync;
  logic          r_vsync;
  logic [9:0]    w_h_next;
  logic [9:0]    w_v_next;
  logic          w_p_tick;
  logic          w_h_wrap;

  assign w_p_tick = (r_div_cnt == DIV_MAX);
  assign w_h_wrap = (r_h_cnt == H_MAX);

  always_comb begin
    w_h_next = r_h_cnt;
    w_v_next = r_v_cnt;
    if (w_p_tick) begin
      if (w_h_wrap) begin
        w_h_next = '0;
        w_v_next = (r_v_cnt == V_MAX) ? '0 : r_v_cnt + 10'd1;
      end else begin
        w_h_next = r_h_cnt + 10'd1;
      end
    end
  end

  // Syncs decode the next counter values so they line up with pixel_x/pixel_y.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_cnt <= '0;
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
      r_hsync   <= 1'b1;
      r_vsync   <= 1'b1;
    end else begin
      r_div_cnt <= w_p_tick ? '0 : r_div_cnt + 1'b1;
      r_h_cnt   <= w_h_next;
      r_v_cnt   <= w_v_next;
      r_hsync   <= !((w_h_next >= HS_FIRST) && (w_h_next <= HS_LAST));
      r_vsync   <= !((w_v_next >= VS_FIRST) && (w_v_next <= VS_LAST));
    end
  end

  assign p_tick   = w_p_tick;
  assign hsync    = r_hsync;
  assign vsync    = r_vsync;
  assign pixel_x  = r_h_cnt;
  assign pixel_y  = r_v_cnt;
  assign video_on = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);

`ifdef VGA_REFRESH_TICK_EN
  // Pulses on the tick that moves the scan from the last visible line into blanking.
  assign refr_tick = w_p_tick && w_h_wrap && (r_v_cnt == V_VIS - 10'd1);
`endif

endmodule
